reg_table_streamer: RTL and testbench

- Upstream feeder for the register-writer stage of the signal generator.
- On a START_REG rising edge, reads a table of register records from a block RAM and emits it as an AXI4-Stream of 32-bit words.
- Each record is 1 address word followed by NREG register words; tlast is set on the final word of the final record.
- A small internal FIFO absorbs the fixed memory read latency, so downstream backpressure never drops or duplicates data.

---
 rtl/sig_gen_pkg.sv | 5 +
 rtl/stream_fifo.sv | 38 +++
 rtl/synchronizer_n.sv | 21 ++
 rtl/reg_table_streamer.sv | 113 +++++++++++
 tb/tb_reg_table_streamer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/sig_gen_pkg.sv
// sig_gen_pkg: shared FSM state encoding and AXIS width for the signal generator.
package sig_gen_pkg;
    localparam int AXIS_W = 32;
    typedef enum logic [2:0] {IDLE, LOAD, READ, DRAIN, END} state_t;
endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: synchronous FIFO with occupancy count and a zeroed head when empty.
module stream_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_head,
    output logic [CW-1:0] o_count
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_count;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= nxt(r_wr);
            end
            if (i_pop) r_rd <= nxt(r_rd);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end
    assign o_head  = (r_count == '0) ? '0 : r_mem[r_rd];
    assign o_count = r_count;
endmodule

// File: rtl/synchronizer_n.sv
// synchronizer_n: multi-flop synchroniser for asynchronous control inputs.
module synchronizer_n #(
    parameter int STAGES = 2,
    parameter int W      = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_sync [STAGES];
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end
    assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/reg_table_streamer.sv
// reg_table_streamer: streams a table of {address, NREG registers} records from
// block RAM as AXI4-Stream words, throttling reads so the FIFO never overflows.
module reg_table_streamer
    import sig_gen_pkg::*;
#(
    parameter int N          = 10,
    parameter int NREG       = 8,
    parameter int MEM_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    output logic [N-1:0]      mem_addr,
    input  logic [AXIS_W-1:0] mem_dout,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [AXIS_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              busy,
    input  logic              START_REG,
    input  logic [N-1:0]      ADDR_REG,
    input  logic [15:0]       LEN_REG
);
    localparam int WCW = $clog2(NREG + 1);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    state_t             r_state;
    logic [N-1:0]       r_rd_addr;
    logic [15:0]        r_rec_left;
    logic [WCW-1:0]     r_word_cnt;
    logic               r_busy;
    logic [MEM_LAT-1:0] r_pv, r_pl;
    logic               w_start, w_issue, w_last, w_pop, w_wrap;
    logic [CW-1:0]      w_count;
    logic [CW:0]        w_inflight, w_occ;
    logic [AXIS_W:0]    w_head;

    synchronizer_n #(.STAGES(2), .W(1)) u_sync (
        .clk (clk),
        .rstn(rstn),
        .i_d (START_REG),
        .o_q (w_start)
    );

    // Reads in flight plus buffered words bound the FIFO fill, so issue only with room left.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) w_inflight = w_inflight + (CW+1)'(r_pv[i]);
        w_occ = (CW+1)'(w_count) + w_inflight;
    end

    assign w_wrap  = r_word_cnt == WCW'(NREG);
    assign w_last  = (r_rec_left == 16'd1) && w_wrap;
    assign w_issue = (r_state == READ) && (w_occ < (CW+1)'(FIFO_DEPTH));
    assign w_pop   = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_rd_addr  <= '0;
            r_rec_left <= '0;
            r_word_cnt <= '0;
            r_busy     <= 1'b0;
            r_pv       <= '0;
            r_pl       <= '0;
        end else begin
            r_pv[0] <= w_issue;
            r_pl[0] <= w_issue && w_last;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pl[i] <= r_pl[i-1];
            end
            case (r_state)
                IDLE: if (w_start) r_state <= LOAD;
                LOAD: begin
                    r_rd_addr  <= ADDR_REG;
                    r_rec_left <= LEN_REG;
                    r_word_cnt <= '0;
                    r_busy     <= LEN_REG != 16'd0;
                    r_state    <= (LEN_REG == 16'd0) ? END : READ;
                end
                READ: if (w_issue) begin
                    r_rd_addr  <= r_rd_addr + 1'b1;
                    r_word_cnt <= w_wrap ? '0 : r_word_cnt + 1'b1;
                    r_rec_left <= w_wrap ? r_rec_left - 1'b1 : r_rec_left;
                    r_state    <= w_last ? DRAIN : READ;
                end
                DRAIN: if (w_pop && w_head[AXIS_W]) begin
                    r_busy  <= 1'b0;
                    r_state <= END;
                end
                END: if (!w_start) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    stream_fifo #(.W(AXIS_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .i_push (r_pv[MEM_LAT-1]),
        .i_data ({r_pl[MEM_LAT-1], mem_dout}),
        .i_pop  (w_pop),
        .o_head (w_head),
        .o_count(w_count)
    );

    assign mem_addr      = r_rd_addr;
    assign m_axis_tvalid = w_count != '0;
    assign m_axis_tdata  = w_head[AXIS_W-1:0];
    assign m_axis_tlast  = w_head[AXIS_W];
    assign busy          = r_busy;
endmodule

// File: tb/tb_reg_table_streamer.sv
// tb_reg_table_streamer: table-driven transfers with a word scoreboard, plus
// hand-written LEN=0, START-hold and mid-transfer reset sequences.
module tb_reg_table_streamer;
    import sig_gen_pkg::*;
    localparam int N = 10, NREG = 8, MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [N-1:0] mem_addr;
    logic [31:0] mem_dout, d1, d2;
    logic        m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast, busy;
    logic [31:0] m_axis_tdata;
    logic        START_REG = 1'b0;
    logic [N-1:0] ADDR_REG = '0;
    logic [15:0] LEN_REG = '0;

    int checks = 0, errors = 0;
    int cyc = 0, words = 0, lasts = 0, first_b = -1, first_v = -1, first_hs = -1, last_hs = -1;
    bit busy_seen = 0, vseen = 0, rand_mode = 0, prev_stall = 0;
    logic [31:0] last_data;
    logic [32:0] prev_word, exp_w;
    logic [32:0] q[$];

    typedef struct {
        logic [N-1:0] addr;
        logic [15:0]  len;
        bit           rnd;
        int           exp_words;
        logic [31:0]  exp_last;
    } vec_t;
    vec_t vecs[4];

    reg_table_streamer #(.N(N), .NREG(NREG), .MEM_LAT(MEM_LAT), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .busy(busy),
        .START_REG(START_REG), .ADDR_REG(ADDR_REG), .LEN_REG(LEN_REG)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memval(input logic [N-1:0] a);
        return 32'hA000_0000 + {22'd0, a};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        d1  <= memval(mem_addr);
        d2  <= d1;
    end
    assign mem_dout = d2;

    initial forever begin
        @(posedge clk);
        #1 m_axis_tready = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (busy) begin
            busy_seen = 1;
            if (first_b < 0) first_b = cyc;
        end
        if (m_axis_tvalid) begin
            vseen = 1;
            if (first_v < 0) first_v = cyc;
        end
        if (prev_stall) begin
            check("hold_valid", 64'(m_axis_tvalid), 64'd1);
            check("hold_data", 64'({m_axis_tlast, m_axis_tdata}), 64'(prev_word));
        end
        if (m_axis_tvalid && m_axis_tready) begin
            words++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            if (m_axis_tlast) begin
                lasts++;
                last_data = m_axis_tdata;
            end
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word: got %0h expected none", {m_axis_tlast, m_axis_tdata});
            end else begin
                exp_w = q.pop_front();
                check("word", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_w));
            end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_word  = {m_axis_tlast, m_axis_tdata};
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_stats();
        words = 0; lasts = 0; first_b = -1; first_v = -1; first_hs = -1; last_hs = -1;
        busy_seen = 0; vseen = 0; last_data = '0;
    endtask

    task automatic push_expected(input logic [N-1:0] a, input logic [15:0] len);
        for (int r = 0; r < int'(len); r++)
            for (int w = 0; w <= NREG; w++)
                q.push_back({(r == int'(len) - 1) && (w == NREG), memval(N'(int'(a) + r * (NREG + 1) + w))});
    endtask

    task automatic wait_busy();
        for (int k = 0; k < 20 && !busy; k++) tick();
        check("busy_rise", 64'(busy), 64'd1);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 3000 && (q.size() != 0 || busy); k++) tick();
        check("drain_bound", 64'(q.size() != 0 || busy), 64'd0);
    endtask

    task automatic run_transfer(input logic [N-1:0] a, input logic [15:0] len, input bit rnd,
                                input int exp_words, input logic [31:0] exp_last);
        rand_mode = rnd;
        ADDR_REG  = a;
        LEN_REG   = len;
        clear_stats();
        push_expected(a, len);
        START_REG = 1'b1;
        wait_busy();
        wait_done();
        check("word_count", 64'(words), 64'(exp_words));
        check("tlast_count", 64'(lasts), 64'd1);
        check("tlast_data", 64'(last_data), 64'(exp_last));
        check("busy_fall", 64'(busy), 64'd0);
        if (!rnd) begin
            check("first_latency", 64'(first_v - first_b), 64'(MEM_LAT + 1));
            check("back_to_back", 64'(last_hs - first_hs), 64'(exp_words - 1));
        end
        START_REG = 1'b0;
        rand_mode = 0;
        repeat (6) tick();
    endtask

    initial begin
        vecs[0] = '{10'h010, 16'd2, 1'b0, 18, 32'hA000_0021};
        vecs[1] = '{10'h010, 16'd2, 1'b1, 18, 32'hA000_0021};
        vecs[2] = '{10'h3FC, 16'd1, 1'b0, 9,  32'hA000_0004};
        vecs[3] = '{10'h3F0, 16'd3, 1'b1, 27, 32'hA000_000A};

        repeat (4) tick();
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rstn = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 4; i++)
            run_transfer(vecs[i].addr, vecs[i].len, vecs[i].rnd, vecs[i].exp_words, vecs[i].exp_last);

        // LEN=0: straight to END, nothing emitted, no re-arm while START stays high
        clear_stats();
        ADDR_REG = 10'h100; LEN_REG = 16'd0; START_REG = 1'b1;
        repeat (10) tick();
        check("len0_state", 64'(dut.r_state), 64'(END));
        check("len0_busy", 64'(busy_seen), 64'd0);
        check("len0_tvalid", 64'(vseen), 64'd0);
        LEN_REG = 16'd1;
        repeat (10) tick();
        check("len0_hold_busy", 64'(busy_seen), 64'd0);
        check("len0_hold_tvalid", 64'(vseen), 64'd0);
        START_REG = 1'b0;
        repeat (6) tick();
        check("len0_rearm", 64'(dut.r_state), 64'(IDLE));

        // START held high, LEN/ADDR changed mid-transfer
        clear_stats();
        ADDR_REG = 10'h010; LEN_REG = 16'd2;
        push_expected(10'h010, 16'd2);
        START_REG = 1'b1;
        wait_busy();
        repeat (3) tick();
        LEN_REG = 16'd5; ADDR_REG = 10'h200;
        wait_done();
        check("hold_words", 64'(words), 64'd18);
        busy_seen = 0; vseen = 0;
        repeat (30) tick();
        check("hold_no_restart_busy", 64'(busy_seen), 64'd0);
        check("hold_no_restart_tvalid", 64'(vseen), 64'd0);
        START_REG = 1'b0;
        repeat (6) tick();
        run_transfer(10'h000, 16'd1, 1'b0, 9, 32'hA000_0008);

        // reset after 5 words aborts; fresh start re-emits from base
        clear_stats();
        ADDR_REG = 10'h010; LEN_REG = 16'd2;
        push_expected(10'h010, 16'd2);
        START_REG = 1'b1;
        for (int k = 0; k < 200 && words < 5; k++) tick();
        check("rst_reach5", 64'(words >= 5), 64'd1);
        rstn = 1'b0;
        START_REG = 1'b0;
        @(posedge clk);
        q.delete();
        @(negedge clk);
        #1;
        check("abort_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("abort_fifo", 64'(dut.u_fifo.r_count), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        repeat (2) tick();
        rstn = 1'b1;
        repeat (3) tick();
        run_transfer(10'h010, 16'd2, 1'b0, 18, 32'hA000_0021);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
